aes_rx_block_decrypt: RTL and testbench

//  Receive-side adapter for the encrypted-ethernet datapath. Packs an incoming ciphertext byte

---
 rtl/aes_rx_block_decrypt_if.sv | 40 ++++
 rtl/aes_rx_block_decrypt.sv | 140 ++++++++++++++
 tb/tb_aes_rx_block_decrypt.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_rx_block_decrypt_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_rx_block_decrypt_if
// Brief    : Bundle of the byte-stream, AES-core and status signals of the
//            receive-side block decrypt adapter.
// Revision : 1.0 - initial release
// ============================================================================
interface aes_rx_block_decrypt_if;
  // ciphertext byte stream in
  logic [7:0]   in_byte;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  // external AES core
  logic [127:0] aes_in;
  logic         aes_inclk;
  logic         aes_outclk;
  logic [127:0] aes_out;
  // plaintext byte stream out
  logic [7:0]   out_byte;
  logic         out_valid;
  logic         out_last;
  logic         out_ready;
  // status
  logic         err;
  logic [15:0]  blk_count;

  // The adapter itself
  modport master (
    input  in_byte, in_valid, in_last, aes_outclk, aes_out, out_ready,
    output in_ready, aes_in, aes_inclk, out_byte, out_valid, out_last, err, blk_count
  );

  // The surrounding environment (source, core, sink)
  modport slave (
    output in_byte, in_valid, in_last, aes_outclk, aes_out, out_ready,
    input  in_ready, aes_in, aes_inclk, out_byte, out_valid, out_last, err, blk_count
  );
endinterface
`default_nettype wire

// File: rtl/aes_rx_block_decrypt.sv
`default_nettype none
// ============================================================================
// Module   : aes_rx_block_decrypt
// Brief    : Packs ciphertext bytes into 128-bit blocks, launches each block
//            into an external AES core in decrypt mode, and serialises the
//            plaintext back out as bytes. One block in flight at a time.
// Revision : 1.0 - initial release
// ============================================================================
module aes_rx_block_decrypt #(
  parameter int TIMEOUT      = 200,
  parameter bit DROP_PARTIAL = 1'b1
) (
  input  wire logic              clk,
  input  wire logic              rst,
  aes_rx_block_decrypt_if.master bus
);

  localparam int c_tmo_w = $clog2(TIMEOUT + 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);
  localparam logic [c_tmo_w-1:0] c_tmo_one  = c_tmo_w'(1);

  localparam logic [1:0] c_collect = 2'd0;
  localparam logic [1:0] c_launch  = 2'd1;
  localparam logic [1:0] c_wait    = 2'd2;
  localparam logic [1:0] c_drain   = 2'd3;

  logic [1:0]         r_state;
  logic               r_run;        // low until the first edge after reset release
  logic [3:0]         r_cnt;        // bytes collected, or bytes drained
  logic [127:0]       r_buf;        // ciphertext block, first byte in [127:120]
  logic [127:0]       r_obuf;       // plaintext block, shifted out from the top
  logic               r_last_tag;
  logic [c_tmo_w-1:0] r_tmo;        // WAIT cycles elapsed since the launch cycle
  logic               r_drop_err;
  logic [15:0]        r_blk_count;

  logic               w_in_ready;
  logic               w_in_xfer;
  logic               w_out_valid;
  logic               w_out_xfer;
  logic               w_tmo_expire;
  logic [127:0]       w_shift;
  logic [127:0]       w_pad;
  logic [3:0]         w_pad_bytes;

  assign w_in_ready  = r_run & (r_state == c_collect);
  assign w_in_xfer   = bus.in_valid & w_in_ready;
  assign w_out_valid = (r_state == c_drain);
  assign w_out_xfer  = w_out_valid & bus.out_ready;

  // Incoming byte appended at the bottom; a short block is then pushed up so
  // its first byte sits in [127:120] and the unused low bytes are zero.
  assign w_shift     = {r_buf[119:0], bus.in_byte};
  assign w_pad_bytes = 4'd15 - r_cnt;
  assign w_pad       = w_shift << {w_pad_bytes, 3'b000};

  // Expiry is the last WAIT cycle; a result strobe in that same cycle wins.
  assign w_tmo_expire = (r_state == c_wait) & (r_tmo == c_tmo_last) & ~bus.aes_outclk;

  assign bus.in_ready  = w_in_ready;
  assign bus.aes_in    = r_buf;
  assign bus.aes_inclk = (r_state == c_launch);
  assign bus.out_byte  = r_obuf[127:120];
  assign bus.out_valid = w_out_valid;
  assign bus.out_last  = w_out_valid & (r_cnt == 4'd15) & r_last_tag;
  assign bus.err       = r_drop_err | w_tmo_expire;
  assign bus.blk_count = r_blk_count;

  // Block state machine: collect, launch, wait for the core, drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= c_collect;
      r_run       <= 1'b0;
      r_cnt       <= 4'd0;
      r_buf       <= '0;
      r_obuf      <= '0;
      r_last_tag  <= 1'b0;
      r_tmo       <= '0;
      r_drop_err  <= 1'b0;
      r_blk_count <= 16'd0;
    end else begin
      r_run      <= 1'b1;
      r_drop_err <= 1'b0;
      case (r_state)
        c_collect: begin
          if (w_in_xfer) begin
            if (r_cnt == 4'd15) begin
              r_buf      <= w_shift;
              r_last_tag <= bus.in_last;
              r_cnt      <= 4'd0;
              r_state    <= c_launch;
            end else if (bus.in_last) begin
              r_cnt <= 4'd0;
              if (DROP_PARTIAL) begin
                r_buf      <= '0;
                r_drop_err <= 1'b1;
              end else begin
                r_buf      <= w_pad;
                r_last_tag <= 1'b1;
                r_state    <= c_launch;
              end
            end else begin
              r_buf <= w_shift;
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        c_launch: begin
          r_tmo   <= '0;
          r_state <= c_wait;
        end
        c_wait: begin
          if (bus.aes_outclk) begin
            r_obuf  <= bus.aes_out;
            r_state <= c_drain;
          end else if (r_tmo == c_tmo_last) begin
            r_state <= c_collect;
          end else begin
            r_tmo <= r_tmo + c_tmo_one;
          end
        end
        c_drain: begin
          if (w_out_xfer) begin
            r_obuf <= {r_obuf[119:0], 8'h00};
            if (r_cnt == 4'd15) begin
              r_cnt       <= 4'd0;
              r_blk_count <= r_blk_count + 16'd1;
              r_state     <= c_collect;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        default: r_state <= c_collect;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_rx_block_decrypt.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_rx_block_decrypt
// Brief    : Self-checking bench for aes_rx_block_decrypt with a behavioural
//            AES core stand-in and a byte-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_rx_block_decrypt;

  localparam int TMO = 20;
  localparam logic [127:0] T1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] T1_PT = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic rst = 1'b0;

  aes_rx_block_decrypt_if bus();

  aes_rx_block_decrypt #(.TIMEOUT(TMO), .DROP_PARTIAL(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int exp_blk = 0;

  logic [7:0]   out_q[$];
  logic         last_q[$];
  int           err_q[$];
  int           inclk_q[$];
  logic [127:0] aes_in_q[$];
  int           last_in_cyc;
  int           stall_viol, ready_viol;

  bit   ready_rand  = 1'b0;
  bit   core_mute   = 1'b0;
  int   core_lat    = 10;
  logic core_outclk;
  logic spur_outclk = 1'b0;

  initial forever #5 clk = ~clk;

  // AES-128 decrypt stand-in: the FIPS-197 vector for the fixed key, and a
  // fixed bijection for every other block.
  function automatic logic [127:0] core_func(input logic [127:0] ct);
    if (ct == T1_CT) return T1_PT;
    return {ct[63:0], ct[127:64]} ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
  endfunction

  assign bus.aes_outclk = core_outclk | spur_outclk;

  // Core stand-in: latches the block on aes_inclk, answers core_lat cycles later
  logic [127:0] core_blk;
  int           core_tmr;
  bit           core_busy;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_busy   <= 1'b0;
      core_tmr    <= 0;
      core_outclk <= 1'b0;
      core_blk    <= '0;
      bus.aes_out <= '0;
    end else begin
      core_outclk <= 1'b0;
      if (bus.aes_inclk) begin
        core_busy <= !core_mute;
        core_tmr  <= core_lat;
        core_blk  <= bus.aes_in;
      end else if (core_busy) begin
        if (core_tmr <= 1) begin
          core_outclk <= 1'b1;
          bus.aes_out <= core_func(core_blk);
          core_busy   <= 1'b0;
        end else begin
          core_tmr <= core_tmr - 1;
        end
      end
    end
  end

  // Downstream sink: always ready, or a random accept pattern
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: logs transfers and strobes on the falling edge
  initial begin : monitor
    logic [7:0] prev_byte;
    bit         prev_stall;
    bit         busy;
    int         busy_out;
    prev_byte = '0; prev_stall = 0; busy = 0; busy_out = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        prev_stall = 0; busy = 0; busy_out = 0;
      end else begin
        if (prev_stall && (!bus.out_valid || bus.out_byte !== prev_byte)) stall_viol++;
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_byte  = bus.out_byte;
        if (bus.in_valid && bus.in_ready) last_in_cyc = cyc;
        if (bus.aes_inclk) begin
          busy = 1; busy_out = 0;
          inclk_q.push_back(cyc);
          aes_in_q.push_back(bus.aes_in);
        end
        if (busy && bus.in_ready) ready_viol++;
        if (bus.err) begin
          err_q.push_back(cyc);
          busy = 0;
        end
        if (bus.out_valid && bus.out_ready) begin
          out_q.push_back(bus.out_byte);
          last_q.push_back(bus.out_last);
          busy_out++;
          if (busy_out == 16) begin busy = 0; busy_out = 0; end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not reach its end, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_logs();
    out_q.delete(); last_q.delete(); err_q.delete();
    inclk_q.delete(); aes_in_q.delete();
    stall_viol = 0; ready_viol = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l, output bit ok);
    int n = 0;
    bus.in_byte = b; bus.in_valid = 1'b1; bus.in_last = l;
    ok = 1'b0;
    while (!ok && n < 300) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] ct, input logic last, output bit ok);
    bit okb;
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send_byte(ct[127-8*i -: 8], last && (i == 15), okb);
      ok &= okb;
    end
  endtask

  task automatic wait_out(input int n);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (out_q.size() >= n) break;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.in_byte = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.aes_inclk, bus.err, bus.out_last} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b required 00000",
               {bus.in_ready, bus.out_valid, bus.aes_inclk, bus.err, bus.out_last});
    end
    checks++;
    if (bus.blk_count !== 16'd0 || bus.out_byte !== 8'd0 || bus.aes_in !== 128'd0) begin
      errors++;
      $display("FAIL reset_data: got blk=%h byte=%h aes_in=%h required all zero",
               bus.blk_count, bus.out_byte, bus.aes_in);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: got %b required 0", bus.in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_edge: got %b required 1", bus.in_ready);
    end
  endtask

  task automatic test_single();
    bit ok;
    clear_logs();
    send_block(T1_CT, 1'b1, ok);
    wait_out(16);
    exp_blk++;
    checks++;
    if (!ok || out_q.size() != 16) begin
      errors++;
      $display("FAIL t1_count: got %0d bytes (in ok=%0d) required 16", out_q.size(), ok);
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (out_q[i] !== 8'(i * 17) || last_q[i] !== (i == 15)) begin
          errors++;
          $display("FAIL t1_byte%0d: got %h last=%b required %h last=%b",
                   i, out_q[i], last_q[i], 8'(i * 17), (i == 15));
        end
      end
    end
    checks++;
    if (aes_in_q.size() != 1 || aes_in_q[0] !== T1_CT) begin
      errors++;
      $display("FAIL t1_aes_in: got %0d launches required 1 of %h", aes_in_q.size(), T1_CT);
    end
    checks++;
    if (bus.blk_count !== 16'(exp_blk) || err_q.size() != 0) begin
      errors++;
      $display("FAIL t1_status: got blk=%0d errs=%0d required blk=%0d errs=0",
               bus.blk_count, err_q.size(), exp_blk);
    end
  endtask

  task automatic test_stall();
    bit ok;
    int bad;
    clear_logs();
    ready_rand = 1'b1;
    send_block(T1_CT, 1'b1, ok);
    wait_out(16);
    ready_rand = 1'b0;
    exp_blk++;
    bad = 0;
    for (int i = 0; i < out_q.size(); i++)
      if (out_q[i] !== 8'(i * 17) || last_q[i] !== (i == 15)) bad++;
    checks++;
    if (out_q.size() != 16 || bad != 0) begin
      errors++;
      $display("FAIL t2_stream: got %0d bytes with %0d wrong required 16 with 0 wrong",
               out_q.size(), bad);
    end
    checks++;
    if (stall_viol != 0) begin
      errors++;
      $display("FAIL t2_hold: got %0d unstable stall cycles required 0", stall_viol);
    end
    checks++;
    if (bus.blk_count !== 16'(exp_blk)) begin
      errors++;
      $display("FAIL t2_blk: got %0d required %0d", bus.blk_count, exp_blk);
    end
  endtask

  task automatic test_back_to_back();
    bit ok0, ok1;
    int bad;
    clear_logs();
    send_block(T1_CT, 1'b0, ok0);
    send_block(T1_CT, 1'b1, ok1);
    wait_out(32);
    exp_blk += 2;
    bad = 0;
    for (int i = 0; i < out_q.size(); i++)
      if (out_q[i] !== 8'((i % 16) * 17) || last_q[i] !== (i == 31)) bad++;
    checks++;
    if (!(ok0 && ok1) || out_q.size() != 32 || bad != 0) begin
      errors++;
      $display("FAIL t3_stream: got %0d bytes with %0d wrong required 32 with 0 wrong",
               out_q.size(), bad);
    end
    checks++;
    if (ready_viol != 0) begin
      errors++;
      $display("FAIL t3_ready: got in_ready high in %0d busy cycles required 0", ready_viol);
    end
    checks++;
    if (bus.blk_count !== 16'(exp_blk)) begin
      errors++;
      $display("FAIL t3_blk: got %0d required %0d", bus.blk_count, exp_blk);
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [127:0] ct, pt;
    logic last;
    int bad;
    for (int k = 0; k < 6; k++) begin
      clear_logs();
      ct = {$urandom(), $urandom(), $urandom(), $urandom()};
      last = 1'($urandom_range(0, 1));
      core_lat = $urandom_range(1, 15);
      ready_rand = 1'b1;
      pt = core_func(ct);
      send_block(ct, last, ok);
      wait_out(16);
      ready_rand = 1'b0;
      exp_blk++;
      bad = 0;
      for (int i = 0; i < out_q.size(); i++)
        if (out_q[i] !== pt[127-8*i -: 8] || last_q[i] !== (last && i == 15)) bad++;
      checks++;
      if (!ok || out_q.size() != 16 || bad != 0 || stall_viol != 0) begin
        errors++;
        $display("FAIL rand%0d: got %0d bytes, %0d wrong, %0d stall slips required 16, 0, 0",
                 k, out_q.size(), bad, stall_viol);
      end
      checks++;
      if (aes_in_q.size() != 1 || aes_in_q[0] !== ct) begin
        errors++;
        $display("FAIL rand%0d_aes_in: got %0d launches required one of %h", k, aes_in_q.size(), ct);
      end
    end
    core_lat = 10;
    checks++;
    if (bus.blk_count !== 16'(exp_blk)) begin
      errors++;
      $display("FAIL rand_blk: got %0d required %0d", bus.blk_count, exp_blk);
    end
  endtask

  task automatic test_drop();
    bit ok, okb;
    int bad;
    clear_logs();
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_byte(8'($urandom()), i == 4, okb);
      ok &= okb;
    end
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (!ok || err_q.size() != 1) begin
      errors++;
      $display("FAIL t4_err_count: got %0d err cycles required 1", err_q.size());
    end else begin
      checks++;
      if (err_q[0] != last_in_cyc + 1) begin
        errors++;
        $display("FAIL t4_err_time: got cycle %0d required %0d", err_q[0], last_in_cyc + 1);
      end
    end
    checks++;
    if (inclk_q.size() != 0 || out_q.size() != 0) begin
      errors++;
      $display("FAIL t4_no_launch: got %0d launches %0d bytes required 0 and 0",
               inclk_q.size(), out_q.size());
    end
    // a stray result strobe while collecting must be ignored
    spur_outclk = 1'b1;
    @(posedge clk);
    #1;
    spur_outclk = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (out_q.size() != 0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL t4_stray_outclk: got %0d bytes valid=%b ready=%b required 0, 0, 1",
               out_q.size(), bus.out_valid, bus.in_ready);
    end
    send_block(T1_CT, 1'b1, ok);
    wait_out(16);
    exp_blk++;
    bad = 0;
    for (int i = 0; i < out_q.size(); i++)
      if (out_q[i] !== 8'(i * 17)) bad++;
    checks++;
    if (!ok || out_q.size() != 16 || bad != 0 || err_q.size() != 1) begin
      errors++;
      $display("FAIL t4_recover: got %0d bytes, %0d wrong, %0d errs required 16, 0, 1",
               out_q.size(), bad, err_q.size());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_logs();
    core_mute = 1'b1;
    send_block(T1_CT, 1'b1, ok);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (err_q.size() > 0) break;
    end
    checks++;
    if (!ok || err_q.size() != 1 || inclk_q.size() != 1) begin
      errors++;
      $display("FAIL t5_err_seen: got %0d errs %0d launches required 1 and 1",
               err_q.size(), inclk_q.size());
    end else begin
      checks++;
      if (err_q[0] - inclk_q[0] != TMO) begin
        errors++;
        $display("FAIL t5_err_time: got %0d cycles after launch required %0d",
                 err_q[0] - inclk_q[0], TMO);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL t5_after: got ready=%b err=%b required 1 and 0", bus.in_ready, bus.err);
    end
    @(posedge clk);
    #1;
    core_mute = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (out_q.size() != 0 || bus.blk_count !== 16'(exp_blk)) begin
      errors++;
      $display("FAIL t5_no_output: got %0d bytes blk=%0d required 0 and %0d",
               out_q.size(), bus.blk_count, exp_blk);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int bad;
    clear_logs();
    send_block(T1_CT, 1'b1, ok);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (out_q.size() >= 3) break;
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.aes_inclk, bus.err, bus.out_last} !== 5'b0 ||
        bus.out_byte !== 8'd0 || bus.blk_count !== 16'd0 || bus.aes_in !== 128'd0) begin
      errors++;
      $display("FAIL t6_async_clear: got ctl=%b byte=%h blk=%0d aes_in=%h required all zero",
               {bus.in_ready, bus.out_valid, bus.aes_inclk, bus.err, bus.out_last},
               bus.out_byte, bus.blk_count, bus.aes_in);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_blk = 0;
    @(posedge clk);
    #1;
    clear_logs();
    send_block(T1_CT, 1'b1, ok);
    wait_out(16);
    exp_blk++;
    bad = 0;
    for (int i = 0; i < out_q.size(); i++)
      if (out_q[i] !== 8'(i * 17) || last_q[i] !== (i == 15)) bad++;
    checks++;
    if (!ok || out_q.size() != 16 || bad != 0 || err_q.size() != 0) begin
      errors++;
      $display("FAIL t6_fresh: got %0d bytes, %0d wrong, %0d errs required 16, 0, 0",
               out_q.size(), bad, err_q.size());
    end
    checks++;
    if (bus.blk_count !== 16'(exp_blk)) begin
      errors++;
      $display("FAIL t6_blk: got %0d required %0d", bus.blk_count, exp_blk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_random();
    test_drop();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
